mod_exp_ctrl: RTL and testbench

Left-to-right square-and-multiply sequencer for RSA modular exponentiation, result = msg^exp mod n.
Acts as the initiator on the Montgomery multiplier start/finish interface. It drives operands and a start pulse, waits for finish, and captures the product.
The multiplier is instantiated beside it in the top level. The multiplier computes A*B*R^-1 mod N with R = 2^WIDTH.
The host supplies r2 = R^2 mod n, precomputed off-chip.

---
 rtl/mod_exp_pkg.sv | 8 +
 rtl/mod_exp_ctrl_if.sv | 7 +
 rtl/mod_exp_ctrl_mm_issue.sv | 47 ++++
 rtl/mod_exp_ctrl.sv | 95 +++++++++
 tb/tb_mod_exp_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mod_exp_pkg.sv
// mod_exp_pkg: shared states and constants for the modular exponentiation sequencer
package mod_exp_pkg;
  localparam int DEF_WIDTH = 256;
  localparam int DEF_EXP_WIDTH = 256;
  localparam logic [DEF_WIDTH-1:0] ONE_W = DEF_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, PRE_M, PRE_A, SQR, MUL, POST, DONE} state_t;
  typedef enum logic {ISS_IDLE, ISS_WAIT} iss_t;
endpackage

// File: rtl/mod_exp_ctrl_if.sv
// mod_exp_ctrl_if: start/finish operand bus between the exponent sequencer and the Montgomery multiplier
interface mod_exp_ctrl_if #(parameter int WIDTH = mod_exp_pkg::DEF_WIDTH);
  logic [WIDTH-1:0] mm_a, mm_b, mm_n, mm_result;
  logic mm_start, mm_finish;
  modport master (output mm_a, mm_b, mm_n, mm_start, input mm_finish, mm_result);
  modport slave (input mm_a, mm_b, mm_n, mm_start, output mm_finish, mm_result);
endinterface

// File: rtl/mod_exp_ctrl_mm_issue.sv
// mm_issue: one-shot issue/wait handshake that pulses start, holds operands and flags capture on finish
module mm_issue
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             finish_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             start_o,
  output logic             cap_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);
  iss_t st_q, st_d;
  logic start_q, start_d, fire;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q    <= ISS_IDLE;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      st_q    <= st_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  // Returning to idle for a cycle after capture spaces issues so the multiplier is waiting again
  always_comb begin
    fire    = st_q == ISS_IDLE && req_i;
    st_d    = fire ? ISS_WAIT : cap_o ? ISS_IDLE : st_q;
    start_d = fire;
    a_d     = fire ? a_i : a_q;
    b_d     = fire ? b_i : b_q;
  end
  always_comb begin
    cap_o   = st_q == ISS_WAIT && finish_i;
    start_o = start_q;
    a_o     = a_q;
    b_o     = b_q;
  end
endmodule

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer computing msg^exp mod n via Montgomery products
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     msg,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     n,
  input  logic [WIDTH-1:0]     r2,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  mod_exp_ctrl_if.master       mm
);
  localparam int IW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(ONE_W);
  state_t state_q, state_d;
  logic [WIDTH-1:0] msg_q, msg_d, n_q, n_d, r2_q, r2_d, mp_q, mp_d, acc_q, acc_d, res_q, res_d;
  logic [WIDTH-1:0] op_a, op_b;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [IW-1:0] i_q, i_d;
  logic accept, cap, req, last, step;
  mm_issue #(.WIDTH(WIDTH)) u_issue (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .finish_i (mm.mm_finish),
    .a_i      (op_a),
    .b_i      (op_b),
    .start_o  (mm.mm_start),
    .cap_o    (cap),
    .a_o      (mm.mm_a),
    .b_o      (mm.mm_b)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      msg_q   <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      r2_q    <= '0;
      mp_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      exp_q   <= exp_d;
      n_q     <= n_d;
      r2_q    <= r2_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      i_q     <= i_d;
    end
  always_comb begin
    last   = i_q == '0;
    accept = state_q == IDLE && start;
    case (state_q)
      IDLE:    state_d = start ? PRE_M : IDLE;
      PRE_M:   state_d = cap ? PRE_A : PRE_M;
      PRE_A:   state_d = cap ? SQR : PRE_A;
      SQR:     state_d = !cap ? SQR : exp_q[i_q] ? MUL : last ? POST : SQR;
      MUL:     state_d = !cap ? MUL : last ? POST : SQR;
      POST:    state_d = cap ? DONE : POST;
      default: state_d = IDLE;
    endcase
    msg_d = accept ? msg : msg_q;
    exp_d = accept ? exp : exp_q;
    n_d   = accept ? n : n_q;
    r2_d  = accept ? r2 : r2_q;
    mp_d  = cap && state_q == PRE_M ? mm.mm_result : mp_q;
    acc_d = cap && (state_q == PRE_A || state_q == SQR || state_q == MUL) ? mm.mm_result : acc_q;
    res_d = cap && state_q == POST ? mm.mm_result : res_q;
    step  = cap && !last && (state_q == MUL || (state_q == SQR && !exp_q[i_q]));
    i_d   = cap && state_q == PRE_A ? I_TOP : step ? i_q - 1'b1 : i_q;
  end
  // Operands stay in the Montgomery domain until POST multiplies by 1 to leave it
  always_comb begin
    busy   = state_q != IDLE && state_q != DONE;
    done   = state_q == DONE;
    req    = busy;
    result = res_q;
    op_a   = state_q == PRE_M ? msg_q : state_q == PRE_A ? ONE : acc_q;
    op_b   = state_q == PRE_M || state_q == PRE_A ? r2_q : state_q == MUL ? mp_q : state_q == POST ? ONE : acc_q;
  end
  assign mm.mm_n = n_q;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: scoreboard bench with a behavioural Montgomery multiplier and modpow reference
module tb_mod_exp_ctrl;
  localparam int W = 8, EW = 8, LAT = 5;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] msg = 0, n = 0, r2 = 0, result;
  logic [EW-1:0] exp_v = 0;
  logic busy, done;
  int errors = 0, checks = 0, cyc = 0, op_count = 0, done_cnt = 0, cur_n = 0;
  typedef struct {int res; int ops; int lat; int start_cyc; int op_base;} exp_t;
  exp_t sb[$];

  mod_exp_ctrl_if #(.WIDTH(W)) mm ();
  mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .exp(exp_v), .n(n), .r2(r2),
    .busy(busy), .done(done), .result(result), .mm(mm)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int mont(int a, int b, int nn);
    int t;
    if (nn <= 0) return 0;
    t = (a * b) % nn;
    for (int x = 0; x < nn; x++) if ((x * 256) % nn == t) return x;
    return 0;
  endfunction

  function automatic int modpow(int m, int e, int nn);
    int r = 1 % nn;
    for (int k = 0; k < e; k++) r = (r * m) % nn;
    return r;
  endfunction

  // Multiplier model: fixed latency, no reset, flags operand movement while the job is live
  initial begin
    int cnt = 0, la = 0, lb = 0, ln = 0;
    bit unstable = 0;
    mm.mm_finish = 0;
    mm.mm_result = 0;
    forever begin
      @(negedge clk);
      mm.mm_finish = 0;
      if (cnt > 0) begin
        if (busy && (mm.mm_a !== W'(la) || mm.mm_b !== W'(lb) || mm.mm_n !== W'(ln))) unstable = 1;
        cnt--;
        if (cnt == 0) begin
          mm.mm_result = W'(mont(la, lb, ln));
          mm.mm_finish = 1;
          chk("operand_stable", 32'(unstable), 0);
          chk("mm_n", ln, cur_n);
        end
      end
      if (mm.mm_start === 1'b1) begin
        la = int'(mm.mm_a); lb = int'(mm.mm_b); ln = int'(mm.mm_n);
        cnt = LAT; unstable = 0; op_count++;
      end
    end
  end

  initial begin
    exp_t x;
    bit prev = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        chk("done_one_cycle", 32'(prev), 0);
        chk("busy_at_done", 32'(busy), 0);
        chk("done_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          x = sb.pop_front();
          chk("result", 32'(result), x.res);
          chk("op_count", op_count - x.op_base, x.ops);
          chk("latency", cyc - x.start_cyc + 1, x.lat);
        end
      end
      prev = done;
    end
  end

  task automatic issue_job(int m, int e, int nn, output int lat);
    exp_t x;
    @(negedge clk);
    msg = W'(m); exp_v = EW'(e); n = W'(nn); r2 = W'(65536 % nn); start = 1; cur_n = nn;
    x.res = modpow(m, e, nn);
    x.ops = 3 + EW + $countones(e);
    x.lat = x.ops * (LAT + 2) + 2;
    x.start_cyc = cyc;
    x.op_base = op_count;
    sb.push_back(x);
    lat = x.lat;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_done(int bound);
    int k = 0;
    do begin @(negedge clk); k++; end while (done !== 1'b1 && k < bound);
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic run_job(int m, int e, int nn);
    int lat;
    issue_job(m, e, nn, lat);
    wait_done(lat + 20);
  endtask

  initial begin
    int lat, saved, nn;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_mm_start", 32'(mm.mm_start), 0);
    chk("rst_mm_a", 32'(mm.mm_a), 0);
    chk("rst_mm_b", 32'(mm.mm_b), 0);
    chk("rst_mm_n", 32'(mm.mm_n), 0);
    rst_n = 1;
    run_job(4, 3, 13);
    run_job(7, 0, 13);
    run_job(0, 255, 13);
    @(negedge clk);
    msg = 9; exp_v = 8'hB7; n = 13; r2 = 3; start = 1; cur_n = 13;
    @(negedge clk);
    start = 0;
    repeat (24) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 1);
    saved = done_cnt;
    #2 rst_n = 0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_result", 32'(result), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("idle_after_stale_finish", 32'(busy), 0);
    chk("no_done_after_abort", done_cnt, saved);
    chk("result_cleared", 32'(result), 0);
    run_job(2, 5, 13);
    issue_job(5, 7, 13, lat);
    repeat (30) @(negedge clk);
    msg = 3; exp_v = 1; n = 7; r2 = 2; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(lat);
    msg = 3; exp_v = 1; n = 7; r2 = 2; start = 1;
    @(negedge clk);
    start = 0;
    saved = op_count;
    chk("busy_after_done_start", 32'(busy), 0);
    repeat (10) @(negedge clk);
    chk("no_op_after_done_start", op_count, saved);
    chk("result_held", 32'(result), modpow(5, 7, 13));
    run_job(250, 2, 251);
    run_job(250, 2, 251);
    run_job(0, 0, 1);
    run_job(0, 3, 13);
    repeat (12) begin
      nn = $urandom_range(1, 127) * 2 + 1;
      run_job($urandom_range(0, nn - 1), $urandom_range(0, 255), nn);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
